// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one main-memory port between the icache refill path and the
// data-side requester. Instruction misses become BLOCK_WORDS-long line bursts
// (one word per mem_ack_i); data accesses are single-word reads or writes.
// When both sides are pending in IDLE, the side that was not granted last
// wins. Every transaction returns to IDLE for at least one cycle.
//
// Ports
//   clk_i, reset_i        clock (rising edge), synchronous active-high reset
//   ic_req_i/ic_addr_i    refill request and miss address (line-aligned here)
//   ic_abort_i            cancel refill; the in-flight word still completes
//   ic_gnt_o              pulse in first cycle of a refill burst
//   ic_rvalid_o/ic_word_o refill word on rdata_o this cycle and its line index
//   ic_done_o             final word of the line delivered this cycle
//   dc_req_i/dc_we_i/dc_addr_i/dc_wdata_i  single-word data access
//   dc_gnt_o/dc_done_o    first-cycle pulse / completion of data access
//   rdata_o               pass-through of mem_rdata_i
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  memory request, held to ack
//   mem_ack_i/mem_rdata_i memory word completion and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int BLOCK_WORDS = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           ic_req_i,
  input  logic [ADDR_W-1:0]              ic_addr_i,
  input  logic                           ic_abort_i,
  output logic                           ic_gnt_o,
  output logic                           ic_rvalid_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] ic_word_o,
  output logic                           ic_done_o,
  input  logic                           dc_req_i,
  input  logic                           dc_we_i,
  input  logic [ADDR_W-1:0]              dc_addr_i,
  input  logic [DATA_W-1:0]              dc_wdata_i,
  output logic                           dc_gnt_o,
  output logic                           dc_done_o,
  output logic [DATA_W-1:0]              rdata_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  input  logic                           mem_ack_i,
  input  logic [DATA_W-1:0]              mem_rdata_i
);

  localparam int WORD_W   = $clog2(BLOCK_WORDS);
  localparam int LINE_LSB = WORD_W + 2;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((BLOCK_WORDS * 4) - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IC_BURST  = 2'd1,
    DC_ACCESS = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic                r_abort_pend, w_abort_pend_nxt;
  logic                r_last_dc, w_last_dc_nxt;   // 1: last grant went to DC
  logic                r_first, w_first_nxt;       // first cycle of a transaction
  logic                w_grant_ic, w_grant_dc;
  logic                w_last_word;

  logic [ADDR_W-1:0]   r_ic_base;
  logic [ADDR_W-1:0]   r_dc_addr;
  logic                r_dc_we;
  logic [DATA_W-1:0]   r_dc_wdata;

  assign rdata_o = mem_rdata_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_word_cnt_nxt   = r_word_cnt;
    w_abort_pend_nxt = r_abort_pend;
    w_last_dc_nxt    = r_last_dc;
    w_first_nxt      = 1'b0;
    w_grant_ic       = 1'b0;
    w_grant_dc       = 1'b0;
    w_last_word      = (r_word_cnt == WORD_W'(BLOCK_WORDS - 1));
    ic_gnt_o         = 1'b0;
    ic_rvalid_o      = 1'b0;
    ic_word_o        = r_word_cnt;
    ic_done_o        = 1'b0;
    dc_gnt_o         = 1'b0;
    dc_done_o        = 1'b0;
    mem_req_o        = 1'b0;
    mem_we_o         = 1'b0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;

    case (r_state)
      IDLE: begin
        // Under contention the side not granted last time wins.
        if (ic_req_i && (!dc_req_i || r_last_dc)) begin
          w_grant_ic = 1'b1;
        end else if (dc_req_i) begin
          w_grant_dc = 1'b1;
        end
        if (w_grant_ic) begin
          w_state_nxt   = IC_BURST;
          w_last_dc_nxt = 1'b0;
          w_first_nxt   = 1'b1;
        end else if (w_grant_dc) begin
          w_state_nxt   = DC_ACCESS;
          w_last_dc_nxt = 1'b1;
          w_first_nxt   = 1'b1;
        end
      end

      IC_BURST: begin
        mem_req_o  = 1'b1;
        // OR-ing the word offset into the aligned base keeps the burst in the line.
        mem_addr_o = r_ic_base | {{(ADDR_W - LINE_LSB){1'b0}}, r_word_cnt, 2'b00};
        ic_gnt_o   = r_first;
        if (mem_ack_i) begin
          ic_rvalid_o = 1'b1;
          // An abort ends the burst after the word in flight; on the last
          // word it is indistinguishable from normal completion.
          if (w_last_word || r_abort_pend || ic_abort_i) begin
            ic_done_o        = w_last_word;
            w_state_nxt      = IDLE;
            w_word_cnt_nxt   = '0;
            w_abort_pend_nxt = 1'b0;
          end else begin
            w_word_cnt_nxt = r_word_cnt + 1'b1;
          end
        end else if (ic_abort_i) begin
          w_abort_pend_nxt = 1'b1;
        end
      end

      DC_ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = r_dc_we;
        mem_addr_o  = r_dc_addr;
        mem_wdata_o = r_dc_wdata;
        dc_gnt_o    = r_first;
        if (mem_ack_i) begin
          dc_done_o   = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_word_cnt   <= '0;
      r_abort_pend <= 1'b0;
      r_last_dc    <= 1'b0;
      r_first      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_abort_pend <= w_abort_pend_nxt;
      r_last_dc    <= w_last_dc_nxt;
      r_first      <= w_first_nxt;
    end
  end

  // Request attributes are captured on the grant edge; outputs are gated by
  // state, so these registers need no reset.
  always_ff @(posedge clk_i) begin
    if (w_grant_ic) begin
      r_ic_base <= ic_addr_i & ~OFF_MASK;
    end
    if (w_grant_dc) begin
      r_dc_addr  <= dc_addr_i;
      r_dc_we    <= dc_we_i;
      r_dc_wdata <= dc_wdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int BW = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WW = $clog2(BW);

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_abort_i = 1'b0;
  logic          ic_gnt_o, ic_rvalid_o, ic_done_o;
  logic [WW-1:0] ic_word_o;
  logic          dc_req_i = 1'b0;
  logic          dc_we_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [DW-1:0] dc_wdata_i = '0;
  logic          dc_gnt_o, dc_done_o;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Transaction-level reference: which transaction owns the port (0 none,
  // 1 refill, 2 data), where it is, and what the requesters latched.
  int          m_kind = 0;
  bit          m_first = 1'b0;
  logic [31:0] m_base = '0;
  int          m_word = 0;
  bit          m_abort = 1'b0;
  bit          m_last_dc = 1'b0;
  logic [31:0] m_dc_addr = '0;
  logic [31:0] m_dc_wdata = '0;
  bit          m_dc_we = 1'b0;
  bit          e_ic_end = 1'b0;
  bit          e_dc_end = 1'b0;

  mem_port_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_abort_i(ic_abort_i),
    .ic_gnt_o(ic_gnt_o), .ic_rvalid_o(ic_rvalid_o), .ic_word_o(ic_word_o),
    .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_gnt_o(dc_gnt_o), .dc_done_o(dc_done_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_rdata_i = $urandom;
  endtask

  // Compare DUT to the reference mid-cycle, then advance the reference by
  // the inputs present for this cycle's closing edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_mem_req", mem_req_o, m_kind != 0);
      chk("m_mem_we", mem_we_o, (m_kind == 2) && m_dc_we);
      chk("m_mem_addr", mem_addr_o,
          (m_kind == 1) ? m_base + 32'(4 * m_word) : ((m_kind == 2) ? m_dc_addr : 32'h0));
      chk("m_mem_wdata", mem_wdata_o, (m_kind == 2) ? m_dc_wdata : 32'h0);
      chk("m_ic_gnt", ic_gnt_o, (m_kind == 1) && m_first);
      chk("m_dc_gnt", dc_gnt_o, (m_kind == 2) && m_first);
      chk("m_ic_rvalid", ic_rvalid_o, (m_kind == 1) && mem_ack_i);
      chk("m_ic_word", ic_word_o, (m_kind == 1) ? m_word : 0);
      chk("m_ic_done", ic_done_o, (m_kind == 1) && mem_ack_i && (m_word == BW - 1));
      chk("m_dc_done", dc_done_o, (m_kind == 2) && mem_ack_i);
      chk("m_rdata", rdata_o, mem_rdata_i);
    end
    e_ic_end = 1'b0;
    e_dc_end = 1'b0;
    if (reset_i) begin
      m_kind = 0; m_word = 0; m_abort = 1'b0; m_last_dc = 1'b0; m_first = 1'b0;
    end else if (m_kind == 0) begin
      bit win_ic;
      if (ic_req_i && dc_req_i) win_ic = m_last_dc;   // alternate under contention
      else                      win_ic = ic_req_i;
      if (win_ic) begin
        m_kind = 1; m_first = 1'b1; m_last_dc = 1'b0; m_word = 0;
        m_base = (ic_addr_i / (4 * BW)) * (4 * BW);
      end else if (dc_req_i) begin
        m_kind = 2; m_first = 1'b1; m_last_dc = 1'b1;
        m_dc_addr = dc_addr_i; m_dc_we = dc_we_i; m_dc_wdata = dc_wdata_i;
      end
    end else if (m_kind == 1) begin
      m_first = 1'b0;
      if (mem_ack_i) begin
        if (m_word == BW - 1 || m_abort || ic_abort_i) begin
          m_kind = 0; m_word = 0; m_abort = 1'b0; e_ic_end = 1'b1;
        end else begin
          m_word = m_word + 1;
        end
      end else if (ic_abort_i) begin
        m_abort = 1'b1;
      end
    end else begin
      m_first = 1'b0;
      if (mem_ack_i) begin
        m_kind = 0; e_dc_end = 1'b1;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_ic_gnt"}, ic_gnt_o, 0);
    chk({tag, "_ic_rvalid"}, ic_rvalid_o, 0);
    chk({tag, "_ic_done"}, ic_done_o, 0);
    chk({tag, "_ic_word"}, ic_word_o, 0);
    chk({tag, "_dc_gnt"}, dc_gnt_o, 0);
    chk({tag, "_dc_done"}, dc_done_o, 0);
  endtask

  // Full refill with ack every cycle; optional abort (with ack stall) at
  // word abort_w, optional reset asserted during word rst_w.
  task automatic ic_burst(input logic [31:0] addr, input int abort_w, input int stall,
                          input int rst_w);
    logic [31:0] base;
    base = addr & ~32'(BW * 4 - 1);
    ic_req_i = 1'b1; ic_addr_i = addr; mem_ack_i = 1'b1;
    tick();
    for (int i = 0; i < BW; i++) begin
      if (i == abort_w) begin
        ic_abort_i = 1'b1;
        for (int s = 0; s < stall; s++) begin
          mem_ack_i = 1'b0;
          @(negedge clk);
          chk("stall_rvalid", ic_rvalid_o, 0);
          chk("stall_addr", mem_addr_o, base + 32'(4 * i));
          tick();
          ic_abort_i = 1'b0;
        end
        mem_ack_i = 1'b1;
      end
      if (i == rst_w) reset_i = 1'b1;
      @(negedge clk);
      chk("ic_gnt", ic_gnt_o, i == 0);
      chk("ic_addr", mem_addr_o, base + 32'(4 * i));
      chk("ic_word", ic_word_o, i);
      chk("ic_rvalid", ic_rvalid_o, 1);
      chk("ic_done", ic_done_o, i == BW - 1);
      tick();
      ic_abort_i = 1'b0;
      if (i == rst_w) begin
        reset_i = 1'b0;
        @(negedge clk);
        chk_all_zero("after_rst");
        return;
      end
      if (i == abort_w) break;
    end
    ic_req_i = 1'b0;
  endtask

  initial begin
    bit ic_act, dc_act;
    // Reset state
    reset_i = 1'b1;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    reset_i = 1'b0;

    // 1: plain refill from 0x1034 -> words 0x1000..0x103C
    ic_burst(32'h1034, -1, 0, -1);

    // 2: contention right after reset, DC first, then alternation
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    ic_req_i = 1'b1; ic_addr_i = 32'h4000;
    dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h5000; mem_ack_i = 1'b1;
    tick();
    @(negedge clk);
    chk("t2_dc_gnt_first", dc_gnt_o, 1);
    chk("t2_ic_not_first", ic_gnt_o, 0);
    chk("t2_dc_addr", mem_addr_o, 32'h5000);
    tick(); dc_addr_i = 32'h5004;
    @(negedge clk);
    chk("t2_bubble", mem_req_o, 0);
    tick();
    @(negedge clk);
    chk("t2_ic_gnt", ic_gnt_o, 1);
    chk("t2_ic_addr", mem_addr_o, 32'h4000);
    repeat (15) tick();
    @(negedge clk);
    chk("t2_ic_done", ic_done_o, 1);
    tick(); ic_req_i = 1'b0;
    @(negedge clk);
    chk("t2_bubble2", mem_req_o, 0);
    tick();
    @(negedge clk);
    chk("t2_dc_gnt_again", dc_gnt_o, 1);
    chk("t2_dc_addr2", mem_addr_o, 32'h5004);
    tick(); dc_req_i = 1'b0;
    tick();

    // 3: data write with ack after 3 stall cycles
    dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h2000; dc_wdata_i = 32'hDEADBEEF;
    mem_ack_i = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin dc_addr_i = 32'h0; dc_wdata_i = 32'h0; end
      if (k == 3) mem_ack_i = 1'b1;
      @(negedge clk);
      chk("t3_req", mem_req_o, 1);
      chk("t3_addr", mem_addr_o, 32'h2000);
      chk("t3_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk("t3_we", mem_we_o, 1);
      chk("t3_gnt", dc_gnt_o, k == 0);
      chk("t3_done", dc_done_o, k == 3);
      tick();
    end
    dc_req_i = 1'b0; dc_we_i = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    chk("t3_done_once", dc_done_o, 0);
    tick();

    // 4: abort at word 5 with ack stalled 2 cycles, then fresh refill
    ic_burst(32'h3058, 5, 2, -1);
    ic_burst(32'h3000, -1, 0, -1);

    // 5: reset during word 9, then fresh refill
    ic_burst(32'h6010, -1, 0, 9);
    ic_burst(32'h6010, -1, 0, -1);

    // 6: abort coinciding with ack on word 15
    ic_burst(32'h7FFC, 15, 0, -1);
    tick();

    // Randomized traffic against the reference
    ic_act = 1'b0; dc_act = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (e_ic_end) begin ic_req_i = 1'b0; ic_act = 1'b0; end
      if (e_dc_end) begin dc_req_i = 1'b0; dc_act = 1'b0; end
      if (!ic_act && $urandom_range(0, 3) == 0) begin
        ic_act = 1'b1; ic_req_i = 1'b1; ic_addr_i = $urandom;
      end else if (ic_act && m_kind == 1 && $urandom_range(0, 3) == 0) begin
        ic_addr_i = $urandom;
      end
      if (!dc_act && $urandom_range(0, 3) == 0) begin
        dc_act = 1'b1; dc_req_i = 1'b1; dc_we_i = 1'($urandom_range(0, 1));
        dc_addr_i = $urandom & 32'hFFFF_FFFC; dc_wdata_i = $urandom;
      end else if (dc_act && m_kind == 2 && $urandom_range(0, 3) == 0) begin
        dc_we_i = ~dc_we_i; dc_addr_i = $urandom; dc_wdata_i = $urandom;
      end
      ic_abort_i = ($urandom_range(0, 15) == 0);
      mem_ack_i  = 1'($urandom_range(0, 1));
      reset_i    = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset_i = 1'b0; ic_req_i = 1'b0; dc_req_i = 1'b0; ic_abort_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
